// File: rtl/noc_traffic_pkg.sv
// Shared types and flit field layout for the NoC traffic endpoint.
// Flit layout, MSB first: {head, tail, dest, src, payload}.
package noc_traffic_pkg;

   typedef enum logic {IDLE, SEND} state_e;
   typedef enum logic {SINK, BYPASS} mode_e;

   function automatic int dest_w(input int nodes);
      return (nodes > 1) ? $clog2(nodes) : 1;
   endfunction

   function automatic int flit_w(input int dw, input int pw);
      return 2 + 2 * dw + pw;
   endfunction

   function automatic int head_bit(input int dw, input int pw);
      return flit_w(dw, pw) - 1;
   endfunction

   function automatic int tail_bit(input int dw, input int pw);
      return flit_w(dw, pw) - 2;
   endfunction

   function automatic int dest_lsb(input int dw, input int pw);
      return pw + dw;
   endfunction

   function automatic int src_lsb(input int pw);
      return pw;
   endfunction

endpackage

// File: rtl/noc_traffic_endpoint_if.sv
// Valid/ready flit channel between the endpoint and its router port.
interface noc_traffic_endpoint_if #(parameter int FLIT_W = 22);
   logic              valid;
   logic              ready;
   logic [FLIT_W-1:0] bits;

   modport master (output valid, output bits, input ready);
   modport slave  (input valid, input bits, output ready);
endinterface

// File: rtl/noc_traffic_outreg.sv
// One-entry valid/ready output register shared by generator and loopback.
module noc_traffic_outreg #(parameter int W = 22) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load_i,
   input  logic [W-1:0] load_data_i,
   input  logic         ready_i,
   output logic         valid_o,
   output logic [W-1:0] data_o,
   output logic         empty_o,
   output logic         can_load_o
);
   logic         valid_q;
   logic [W-1:0] data_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         data_q  <= load_data_i;
      end else if (valid_q && ready_i) begin
         valid_q <= 1'b0;
      end
   end

   assign valid_o    = valid_q;
   assign data_o     = data_q;
   assign empty_o    = !valid_q;
   assign can_load_o = !valid_q || ready_i;
endmodule

// File: rtl/noc_traffic_endpoint.sv
// Per-node NoC traffic generator / sink / loopback endpoint.
// Optional payload-sequence checker enabled by defining TRAFFIC_CHECK_EN.
module noc_traffic_endpoint import noc_traffic_pkg::*; #(
   parameter int NUM_NODES  = 3,
   parameter int MY_ID      = 0,
   parameter int DEST_SLOTS = 3,
   parameter int PKT_LEN    = 1,
   parameter int PAYLOAD_W  = 16,
   parameter int COUNT_W    = 32,
   localparam int DEST_W    = dest_w(NUM_NODES),
   localparam int FLIT_W    = flit_w(DEST_W, PAYLOAD_W)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         io_config_valid,
   output logic                         io_config_ready,
   input  logic                         io_config_bits_sequence,
   input  logic [DEST_SLOTS*DEST_W-1:0] io_config_bits_destination,
   input  logic [COUNT_W-1:0]           io_config_bits_count,
   input  logic                         io_bypass,
   noc_traffic_endpoint_if.master       io_out,
   noc_traffic_endpoint_if.slave        io_in,
   output logic [COUNT_W-1:0]           io_count,
   output logic [COUNT_W-1:0]           io_sent,
   output logic [FLIT_W-1:0]            io_dump,
   output logic                         io_busy,
   output logic                         io_error
);
   localparam int HB    = head_bit(DEST_W, PAYLOAD_W);
   localparam int TB    = tail_bit(DEST_W, PAYLOAD_W);
   localparam int DL    = dest_lsb(DEST_W, PAYLOAD_W);
   localparam int SL    = src_lsb(PAYLOAD_W);
   localparam int PTR_W = (DEST_SLOTS > 1) ? $clog2(DEST_SLOTS) : 1;
   localparam int POS_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

   state_e                       state_q;
   mode_e                        mode_q, mode_d;
   logic                         seq_mode_q;
   logic [DEST_SLOTS*DEST_W-1:0] slots_q;
   logic [COUNT_W-1:0]           cnt_q, iss_q, sent_q, count_q;
   logic [PAYLOAD_W-1:0]         seqn_q;
   logic [PTR_W-1:0]             ptr_q;
   logic [POS_W-1:0]             pos_q;
   logic [FLIT_W-1:0]            dump_q;

   logic              can_load, out_empty, out_valid;
   logic [FLIT_W-1:0] out_data, load_flit, gen_flit, byp_flit;
   logic              pending, sw, gen_head, gen_tail, gen_load;
   logic              in_ready, in_hs, byp_load, out_hs;

   always_comb begin
      pending  = io_bypass != (mode_q == BYPASS);
      sw       = pending && out_empty && (pos_q == '0);
      mode_d   = sw ? (io_bypass ? BYPASS : SINK) : mode_q;
      gen_head = pos_q == '0;
      gen_tail = (pos_q == POS_W'(PKT_LEN - 1)) ||
                 ((iss_q + COUNT_W'(1)) == cnt_q);
      // A pending mode switch holds off the next packet head so it can land.
      gen_load = (state_q == SEND) && (mode_q == SINK) && can_load &&
                 (iss_q < cnt_q) && !(pending && gen_head);
      in_ready = (mode_q == SINK) || (can_load && !pending);
      in_hs    = io_in.valid && in_ready;
      byp_load = (mode_q == BYPASS) && in_hs;
      out_hs   = out_valid && io_out.ready;
      gen_flit = {gen_head, gen_tail, slots_q[ptr_q*DEST_W +: DEST_W],
                  DEST_W'(MY_ID), seqn_q};
      byp_flit = {io_in.bits[HB], io_in.bits[TB], io_in.bits[SL +: DEST_W],
                  DEST_W'(MY_ID), io_in.bits[PAYLOAD_W-1:0]};
      load_flit = byp_load ? byp_flit : gen_flit;
   end

   noc_traffic_outreg #(.W(FLIT_W)) u_outreg (
      .clk         (clk),
      .reset       (reset),
      .load_i      (gen_load || byp_load),
      .load_data_i (load_flit),
      .ready_i     (io_out.ready),
      .valid_o     (out_valid),
      .data_o      (out_data),
      .empty_o     (out_empty),
      .can_load_o  (can_load)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         mode_q     <= SINK;
         seq_mode_q <= 1'b0;
         slots_q    <= '0;
         cnt_q      <= '0;
         iss_q      <= '0;
         sent_q     <= '0;
         count_q    <= '0;
         seqn_q     <= '0;
         ptr_q      <= '0;
         pos_q      <= '0;
         dump_q     <= '0;
      end else begin
         mode_q <= mode_d;
         if ((mode_q == SINK) && in_hs) begin
            count_q <= count_q + COUNT_W'(1);
            dump_q  <= io_in.bits;
         end
         unique case (state_q)
            IDLE: begin
               if (io_config_valid) begin
                  seq_mode_q <= io_config_bits_sequence;
                  slots_q    <= io_config_bits_destination;
                  cnt_q      <= io_config_bits_count;
                  iss_q      <= '0;
                  sent_q     <= '0;
                  seqn_q     <= '0;
                  ptr_q      <= '0;
                  pos_q      <= '0;
                  if (io_config_bits_count != '0) state_q <= SEND;
               end
            end
            SEND: begin
               if (gen_load) begin
                  iss_q  <= iss_q + COUNT_W'(1);
                  seqn_q <= seqn_q + PAYLOAD_W'(1);
                  pos_q  <= gen_tail ? '0 : pos_q + POS_W'(1);
                  if (gen_tail && seq_mode_q)
                     ptr_q <= (ptr_q == PTR_W'(DEST_SLOTS - 1)) ?
                              '0 : ptr_q + PTR_W'(1);
               end
               if (out_hs && (mode_q == SINK)) begin
                  sent_q <= sent_q + COUNT_W'(1);
                  if ((sent_q + COUNT_W'(1)) == cnt_q) state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign io_config_ready = !reset && (state_q == IDLE);
   assign io_out.valid    = out_valid;
   assign io_out.bits     = out_data;
   assign io_in.ready     = in_ready;
   assign io_count        = count_q;
   assign io_sent         = sent_q;
   assign io_dump         = dump_q;
   assign io_busy         = state_q == SEND;

`ifdef TRAFFIC_CHECK_EN
   logic [PAYLOAD_W-1:0] exp_q [NUM_NODES];
   logic                 err_q;
   logic [DEST_W-1:0]    in_src;
   logic [PAYLOAD_W-1:0] in_pay;
   logic                 chk;

   assign in_src = io_in.bits[SL +: DEST_W];
   assign in_pay = io_in.bits[PAYLOAD_W-1:0];
   // Pure tail flits of multi-flit packets are not sequence-checked.
   assign chk = (mode_q == SINK) && in_hs &&
                (io_in.bits[HB] || !io_in.bits[TB]) &&
                (int'(in_src) < NUM_NODES);

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_NODES; i++) exp_q[i] <= '0;
         err_q <= 1'b0;
      end else if (chk) begin
         if (in_pay != exp_q[in_src]) err_q <= 1'b1;
         exp_q[in_src] <= in_pay + PAYLOAD_W'(1);
      end
   end

   assign io_error = err_q;
`else
   assign io_error = 1'b0;
`endif
endmodule

// File: tb/tb_noc_traffic_endpoint.sv
// Directed self-checking bench for noc_traffic_endpoint.
// Two instances: A (MY_ID=1, PKT_LEN=1) and B (MY_ID=2, PKT_LEN=3).
module tb_noc_traffic_endpoint;
   localparam int FW = 22;

   logic clk = 1'b0;
   logic reset;
   int   vecs = 0;
   int   errs = 0;

   always #5 clk = ~clk;

   logic        a_cfg_v, a_cfg_r, a_seq, a_byp, a_busy, a_err;
   logic [5:0]  a_dst;
   logic [31:0] a_cnt, a_count, a_sent;
   logic [21:0] a_dump;
   logic        b_cfg_v, b_cfg_r, b_seq, b_byp, b_busy, b_err;
   logic [5:0]  b_dst;
   logic [31:0] b_cnt, b_count, b_sent;
   logic [21:0] b_dump;

   noc_traffic_endpoint_if #(.FLIT_W(FW)) a_out (), a_in (), b_out (), b_in ();

   noc_traffic_endpoint #(.NUM_NODES(3), .MY_ID(1), .PKT_LEN(1)) dut_a (
      .clk(clk), .reset(reset),
      .io_config_valid(a_cfg_v), .io_config_ready(a_cfg_r),
      .io_config_bits_sequence(a_seq),
      .io_config_bits_destination(a_dst),
      .io_config_bits_count(a_cnt), .io_bypass(a_byp),
      .io_out(a_out), .io_in(a_in),
      .io_count(a_count), .io_sent(a_sent), .io_dump(a_dump),
      .io_busy(a_busy), .io_error(a_err));

   noc_traffic_endpoint #(.NUM_NODES(3), .MY_ID(2), .PKT_LEN(3)) dut_b (
      .clk(clk), .reset(reset),
      .io_config_valid(b_cfg_v), .io_config_ready(b_cfg_r),
      .io_config_bits_sequence(b_seq),
      .io_config_bits_destination(b_dst),
      .io_config_bits_count(b_cnt), .io_bypass(b_byp),
      .io_out(b_out), .io_in(b_in),
      .io_count(b_count), .io_sent(b_sent), .io_dump(b_dump),
      .io_busy(b_busy), .io_error(b_err));

   function automatic logic [21:0] mk(input logic h, input logic t,
                                      input logic [1:0] d, input logic [1:0] s,
                                      input logic [15:0] p);
      return {h, t, d, s, p};
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset;
      reset = 1'b1;
      tick;
      reset = 1'b0;
   endtask

   task automatic cfg_a(input logic s, input logic [5:0] d, input int c);
      a_seq = s; a_dst = d; a_cnt = c; a_cfg_v = 1'b1;
      tick;
      a_cfg_v = 1'b0;
   endtask

   task automatic cfg_b(input logic s, input logic [5:0] d, input int c);
      b_seq = s; b_dst = d; b_cnt = c; b_cfg_v = 1'b1;
      tick;
      b_cfg_v = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      a_cfg_v = 0; a_seq = 0; a_dst = 0; a_cnt = 0; a_byp = 0;
      b_cfg_v = 0; b_seq = 0; b_dst = 0; b_cnt = 0; b_byp = 0;
      a_out.ready = 1'b1; a_in.valid = 1'b0; a_in.bits = '0;
      b_out.ready = 1'b1; b_in.valid = 1'b0; b_in.bits = '0;
      tick; tick;
      vecs++; if (a_out.valid !== 1'b0) begin errs++; $display("FAIL rst_valid got %0b want 0", a_out.valid); end
      vecs++; if (a_sent !== 32'd0) begin errs++; $display("FAIL rst_sent got %0d want 0", a_sent); end
      vecs++; if (a_count !== 32'd0) begin errs++; $display("FAIL rst_count got %0d want 0", a_count); end
      vecs++; if (a_dump !== 22'd0) begin errs++; $display("FAIL rst_dump got %h want 0", a_dump); end
      vecs++; if (a_busy !== 1'b0) begin errs++; $display("FAIL rst_busy got %0b want 0", a_busy); end
      vecs++; if (a_err !== 1'b0) begin errs++; $display("FAIL rst_error got %0b want 0", a_err); end
      vecs++; if (a_cfg_r !== 1'b0) begin errs++; $display("FAIL rst_cfg_ready got %0b want 0", a_cfg_r); end
      reset = 1'b0;
      #1;
      vecs++; if (a_cfg_r !== 1'b1) begin errs++; $display("FAIL post_rst_cfg_ready got %0b want 1", a_cfg_r); end
      vecs++; if (b_cfg_r !== 1'b1) begin errs++; $display("FAIL post_rst_cfg_ready_b got %0b want 1", b_cfg_r); end
   endtask

   task automatic test_fixed_dest;
      int n = 0;
      int last = 0;
      a_out.ready = 1'b1;
      cfg_a(1'b0, 6'b000010, 5);
      for (int c = 0; c < 40 && n < 5; c++) begin
         if (a_out.valid && a_out.ready) begin
            vecs++; if (a_out.bits !== mk(1, 1, 2, 1, 16'(n))) begin errs++; $display("FAIL fixed_flit%0d got %h want %h", n, a_out.bits, mk(1, 1, 2, 1, 16'(n))); end
            if (n > 0) begin
               vecs++; if (c != last + 1) begin errs++; $display("FAIL fixed_gap flit%0d cycle %0d want %0d", n, c, last + 1); end
            end
            last = c;
            n++;
         end
         tick;
      end
      vecs++; if (n != 5) begin errs++; $display("FAIL fixed_nflits got %0d want 5", n); end
      vecs++; if (a_sent !== 32'd5) begin errs++; $display("FAIL fixed_sent got %0d want 5", a_sent); end
      vecs++; if (a_cfg_r !== 1'b1) begin errs++; $display("FAIL fixed_cfg_ready got %0b want 1", a_cfg_r); end
      vecs++; if (a_busy !== 1'b0) begin errs++; $display("FAIL fixed_busy got %0b want 0", a_busy); end
   endtask

   task automatic test_packets;
      int n = 0;
      logic [1:0] dexp;
      logic h, t;
      b_out.ready = 1'b1;
      cfg_b(1'b1, {2'd0, 2'd2, 2'd1}, 7);
      for (int c = 0; c < 40 && n < 7; c++) begin
         if (b_out.valid && b_out.ready) begin
            dexp = (n < 3) ? 2'd1 : (n < 6) ? 2'd2 : 2'd0;
            h = (n % 3) == 0;
            t = ((n % 3) == 2) || (n == 6);
            vecs++; if (b_out.bits !== mk(h, t, dexp, 2, 16'(n))) begin errs++; $display("FAIL pkt_flit%0d got %h want %h", n, b_out.bits, mk(h, t, dexp, 2, 16'(n))); end
            n++;
         end
         tick;
      end
      vecs++; if (n != 7) begin errs++; $display("FAIL pkt_nflits got %0d want 7", n); end
      vecs++; if (b_sent !== 32'd7) begin errs++; $display("FAIL pkt_sent got %0d want 7", b_sent); end
      vecs++; if (b_busy !== 1'b0) begin errs++; $display("FAIL pkt_busy got %0b want 0", b_busy); end
   endtask

   task automatic test_backpressure;
      int n = 0;
      logic hold = 1'b0;
      logic [21:0] held = '0;
      a_out.ready = 1'b0;
      cfg_a(1'b0, 6'b000010, 100);
      for (int c = 0; c < 1500 && n < 100; c++) begin
         if (hold) begin
            vecs++; if (!a_out.valid || a_out.bits !== held) begin errs++; $display("FAIL bp_stable got %0b/%h want 1/%h", a_out.valid, a_out.bits, held); end
         end
         hold = 1'b0;
         if (a_out.valid) begin
            if (a_out.ready) begin
               vecs++; if (a_out.bits !== mk(1, 1, 2, 1, 16'(n))) begin errs++; $display("FAIL bp_flit%0d got %h want %h", n, a_out.bits, mk(1, 1, 2, 1, 16'(n))); end
               n++;
            end else begin
               hold = 1'b1;
               held = a_out.bits;
            end
         end
         tick;
         a_out.ready = 1'($urandom_range(0, 1));
      end
      a_out.ready = 1'b1;
      vecs++; if (n != 100) begin errs++; $display("FAIL bp_nflits got %0d want 100", n); end
      vecs++; if (a_sent !== 32'd100) begin errs++; $display("FAIL bp_sent got %0d want 100", a_sent); end
      tick;
      vecs++; if (a_out.valid !== 1'b0) begin errs++; $display("FAIL bp_extra_flit got %0b want 0", a_out.valid); end
   endtask

   task automatic test_bypass;
      logic acc = 1'b0;
      logic seen = 1'b0;
      logic [31:0] cnt0;
      a_out.ready = 1'b1;
      a_byp = 1'b1;
      tick; tick;
      cnt0 = a_count;
      a_in.bits = mk(1, 1, 1, 0, 16'hABCD);
      a_in.valid = 1'b1;
      for (int c = 0; c < 10 && !acc; c++) begin
         if (a_in.ready) acc = 1'b1;
         tick;
      end
      a_in.valid = 1'b0;
      vecs++; if (!acc) begin errs++; $display("FAIL byp_accept got 0 want 1"); end
      for (int c = 0; c < 10 && !seen; c++) begin
         if (a_out.valid) begin
            seen = 1'b1;
            vecs++; if (a_out.bits !== mk(1, 1, 0, 1, 16'hABCD)) begin errs++; $display("FAIL byp_flit got %h want %h", a_out.bits, mk(1, 1, 0, 1, 16'hABCD)); end
         end
         tick;
      end
      vecs++; if (!seen) begin errs++; $display("FAIL byp_out_timeout got 0 want 1"); end
      vecs++; if (a_count !== cnt0) begin errs++; $display("FAIL byp_count got %0d want %0d", a_count, cnt0); end
      a_byp = 1'b0;
      tick; tick;
   endtask

   task automatic test_bypass_midpkt;
      logic acc = 1'b0;
      logic seen = 1'b0;
      b_out.ready = 1'b0;
      b_byp = 1'b0;
      cfg_b(1'b0, 6'b000010, 6);
      tick; tick;
      b_byp = 1'b1;
      tick; tick;
      vecs++; if (b_out.bits !== mk(1, 0, 2, 2, 16'd0) || !b_out.valid) begin errs++; $display("FAIL mid_head got %0b/%h want 1/%h", b_out.valid, b_out.bits, mk(1, 0, 2, 2, 16'd0)); end
      b_out.ready = 1'b1;
      for (int c = 0; c < 10; c++) tick;
      vecs++; if (b_sent !== 32'd3) begin errs++; $display("FAIL mid_sent_stall got %0d want 3", b_sent); end
      vecs++; if (b_busy !== 1'b1) begin errs++; $display("FAIL mid_busy got %0b want 1", b_busy); end
      vecs++; if (b_out.valid !== 1'b0) begin errs++; $display("FAIL mid_gen_stalled got %0b want 0", b_out.valid); end
      b_in.bits = mk(1, 1, 2, 1, 16'h1234);
      b_in.valid = 1'b1;
      for (int c = 0; c < 10 && !acc; c++) begin
         if (b_in.ready) acc = 1'b1;
         tick;
      end
      b_in.valid = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
         if (b_out.valid) begin
            seen = 1'b1;
            vecs++; if (b_out.bits !== mk(1, 1, 1, 2, 16'h1234)) begin errs++; $display("FAIL mid_byp_flit got %h want %h", b_out.bits, mk(1, 1, 1, 2, 16'h1234)); end
         end
         tick;
      end
      vecs++; if (!seen) begin errs++; $display("FAIL mid_byp_timeout got 0 want 1"); end
      b_byp = 1'b0;
      for (int c = 0; c < 40 && b_busy; c++) tick;
      vecs++; if (b_sent !== 32'd6) begin errs++; $display("FAIL mid_sent_final got %0d want 6", b_sent); end
      vecs++; if (b_busy !== 1'b0) begin errs++; $display("FAIL mid_done got %0b want 0", b_busy); end
   endtask

   task automatic test_sink;
      logic [21:0] f [4];
      f[0] = mk(1, 1, 1, 2, 16'h0011);
      f[1] = mk(1, 0, 1, 0, 16'h0022);
      f[2] = mk(0, 1, 1, 0, 16'h0033);
      f[3] = mk(1, 1, 1, 2, 16'h0044);
      pulse_reset;
      a_byp = 1'b0;
      for (int i = 0; i < 4; i++) begin
         a_in.bits = f[i];
         a_in.valid = 1'b1;
         vecs++; if (a_in.ready !== 1'b1) begin errs++; $display("FAIL sink_ready got %0b want 1", a_in.ready); end
         tick;
      end
      a_in.valid = 1'b0;
      vecs++; if (a_count !== 32'd4) begin errs++; $display("FAIL sink_count got %0d want 4", a_count); end
      vecs++; if (a_dump !== f[3]) begin errs++; $display("FAIL sink_dump got %h want %h", a_dump, f[3]); end
      vecs++; if (a_out.valid !== 1'b0) begin errs++; $display("FAIL sink_no_out got %0b want 0", a_out.valid); end
   endtask

   task automatic test_check;
      logic [15:0] p [3];
      logic exp_err;
`ifdef TRAFFIC_CHECK_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      p[0] = 16'd0; p[1] = 16'd1; p[2] = 16'd3;
      pulse_reset;
      for (int i = 0; i < 3; i++) begin
         a_in.bits = mk(1, 1, 1, 2, p[i]);
         a_in.valid = 1'b1;
         tick;
         if (i == 1) begin
            vecs++; if (a_err !== 1'b0) begin errs++; $display("FAIL chk_in_order got %0b want 0", a_err); end
         end
      end
      a_in.valid = 1'b0;
      vecs++; if (a_err !== exp_err) begin errs++; $display("FAIL chk_gap got %0b want %0b", a_err, exp_err); end
      tick;
      vecs++; if (a_err !== exp_err) begin errs++; $display("FAIL chk_sticky got %0b want %0b", a_err, exp_err); end
   endtask

   task automatic test_reset_mid;
      pulse_reset;
      a_out.ready = 1'b1;
      cfg_a(1'b0, 6'b000010, 50);
      for (int c = 0; c < 100 && a_sent != 32'd10; c++) tick;
      vecs++; if (a_sent !== 32'd10) begin errs++; $display("FAIL rmid_reach got %0d want 10", a_sent); end
      reset = 1'b1;
      tick;
      vecs++; if (a_out.valid !== 1'b0) begin errs++; $display("FAIL rmid_valid got %0b want 0", a_out.valid); end
      vecs++; if (a_sent !== 32'd0) begin errs++; $display("FAIL rmid_sent got %0d want 0", a_sent); end
      vecs++; if (a_busy !== 1'b0) begin errs++; $display("FAIL rmid_busy got %0b want 0", a_busy); end
      reset = 1'b0;
      #1;
      vecs++; if (a_cfg_r !== 1'b1) begin errs++; $display("FAIL rmid_cfg_ready got %0b want 1", a_cfg_r); end
      tick;
      vecs++; if (a_out.valid !== 1'b0) begin errs++; $display("FAIL rmid_idle_out got %0b want 0", a_out.valid); end
   endtask

   initial begin
      test_reset;
      test_fixed_dest;
      test_packets;
      test_backpressure;
      test_bypass;
      test_bypass_midpkt;
      test_sink;
      test_check;
      test_reset_mid;
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
